// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the FSM state encoding
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    CLEANUP   = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for asynchronous inputs.
// The reset value is a parameter so that idle-high lines come out of reset idle.
module uart_sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling of the synchronized line,
// one-cycle data-valid and framing-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic r_rx;

  uart_sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (i_Clock),
    .rst_n (i_Reset_n),
    .d     (i_Rx_Serial),
    .q     (r_rx)
  );

  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] byte_q, byte_d;
  logic                      dv_q, dv_d;
  logic                      active_q, active_d;
  logic                      ferr_q, ferr_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    active_d = active_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!r_rx) begin
          state_d  = START;
          active_d = 1'b1;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!r_rx) begin
            state_d = DATA;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = r_rx;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (r_rx) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CLEANUP: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end

      WAIT_IDLE: begin
        // A held-low line (break) must not look like a fresh start bit.
        if (r_rx) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      active_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      active_q <= active_d;
      ferr_q   <= ferr_d;
    end
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Active    = active_q;
  assign o_Rx_Frame_Err = ferr_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are built from bytes, and the expected
// byte stream and error count come from a frame-level model, not from the RTL.
module tb_uart_rx;

  localparam int CPB      = 8;
  localparam int HALF     = (CPB - 1) / 2;
  localparam int EXP_LAT  = 2 + (HALF + 1) + 9 * CPB;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       dv, active, ferr;
  logic [7:0] rbyte;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Reset_n      (rst_n),
    .i_Rx_Serial    (rx),
    .o_Rx_DV        (dv),
    .o_Rx_Byte      (rbyte),
    .o_Rx_Active    (active),
    .o_Rx_Frame_Err (ferr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collects delivered bytes and pulse statistics on the falling edge.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int   exp_err = 0;
  int   dv_cnt = 0, err_cnt = 0, width_bad = 0, both_bad = 0;
  int   last_dv_cyc = 0, active_after_dv_bad = 0, active_gap = 0;
  logic prev_dv = 1'b0, prev_err = 1'b0;

  always @(negedge clk) begin
    if (prev_dv && active) active_after_dv_bad++;
    if (dv) begin
      got_q.push_back(rbyte);
      dv_cnt++;
      last_dv_cyc = cyc;
      if (prev_dv) width_bad++;
    end
    if (ferr) begin
      err_cnt++;
      if (prev_err) width_bad++;
    end
    if (dv && ferr) both_bad++;
    prev_dv  = dv;
    prev_err = ferr;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 10-bit frame; bit skew_bit (0=start, 9=stop) lasts skew_len clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int skew_bit, input int skew_len);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat ((i == skew_bit) ? skew_len : CPB) @(posedge clk);
      #1;
      if (i <= 8 && !active) active_gap++;
    end
    if (stop) begin
      exp_q.push_back(b);
      last_good = b;
    end else begin
      exp_err++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (dv !== 1'b0)      begin bad++; $display("FAIL reset_dv: got %b want 0", dv); end
    total++; if (rbyte !== 8'h00)  begin bad++; $display("FAIL reset_byte: got %h want 00", rbyte); end
    total++; if (active !== 1'b0)  begin bad++; $display("FAIL reset_active: got %b want 0", active); end
    total++; if (ferr !== 1'b0)    begin bad++; $display("FAIL reset_ferr: got %b want 0", ferr); end
    rst_n = 1'b1;
    idle(4);
    total++; if (active !== 1'b0)  begin bad++; $display("FAIL idle_active: got %b want 0", active); end
  endtask

  task automatic test_single();
    int c0, dv0, lat;
    logic [7:0] e, g;
    dv0 = dv_cnt;
    c0  = cyc;
    send_frame(8'hA5, 1'b1, -1, 0);
    idle(3);
    lat = last_dv_cyc - c0;
    total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL single_dv_count: got %0d want 1", dv_cnt - dv0); end
    total++; if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin bad++; $display("FAIL single_latency: got %0d want %0d+-1", lat, EXP_LAT); end
    total++; if (active_gap !== 0) begin bad++; $display("FAIL single_active_gap: got %0d want 0", active_gap); end
    total++; if (active_after_dv_bad !== 0) begin bad++; $display("FAIL single_active_after_dv: got %0d want 0", active_after_dv_bad); end
    total++; if (width_bad !== 0) begin bad++; $display("FAIL single_pulse_width: got %0d want 0", width_bad); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL single_byte: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int err0;
    logic [7:0] e, g;
    err0 = err_cnt;
    send_frame(8'h00, 1'b1, -1, 0);
    send_frame(8'hFF, 1'b1, -1, 0);
    for (int i = 0; i < 6; i++) send_frame(8'($urandom), 1'b1, -1, 0);
    idle(3);
    total++; if (err_cnt !== err0) begin bad++; $display("FAIL b2b_ferr: got %0d want %0d", err_cnt, err0); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL b2b_byte: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    int dv0, err0;
    logic saw;
    dv0 = dv_cnt; err0 = err_cnt; saw = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < HALF + 4; i++) begin
      @(negedge clk);
      saw |= active;
      @(posedge clk);
      if (i == 1) begin #1; rx = 1'b1; end
    end
    @(negedge clk);
    total++; if (saw !== 1'b1)   begin bad++; $display("FAIL glitch_active_seen: got %b want 1", saw); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL glitch_back_idle: got %b want 0", active); end
    idle(2 * CPB);
    total++; if (dv_cnt !== dv0)   begin bad++; $display("FAIL glitch_dv: got %0d want %0d", dv_cnt, dv0); end
    total++; if (err_cnt !== err0) begin bad++; $display("FAIL glitch_ferr: got %0d want %0d", err_cnt, err0); end
  endtask

  task automatic test_frame_err();
    int dv0;
    logic [7:0] prev, e, g;
    dv0 = dv_cnt; prev = last_good;
    send_frame(8'h3C, 1'b0, -1, 0);
    repeat (30) @(posedge clk);
    #1;
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL ferr_count: got %0d want %0d", err_cnt, exp_err); end
    total++; if (dv_cnt !== dv0)      begin bad++; $display("FAIL ferr_no_dv: got %0d want %0d", dv_cnt, dv0); end
    total++; if (rbyte !== prev)      begin bad++; $display("FAIL ferr_byte_kept: got %h want %h", rbyte, prev); end
    total++; if (active !== 1'b1)     begin bad++; $display("FAIL ferr_waiting: got %b want 1", active); end
    idle(4);
    total++; if (active !== 1'b0)     begin bad++; $display("FAIL ferr_released: got %b want 0", active); end
    send_frame(8'h81, 1'b1, -1, 0);
    idle(3);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL ferr_next_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL ferr_next_byte: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int dv0, err0;
    logic [9:0] frame;
    logic [7:0] e, g;
    dv0 = dv_cnt; err0 = err_cnt;
    frame = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = frame[5];
    repeat (4) @(posedge clk);
    #2;
    total++; if (active !== 1'b1) begin bad++; $display("FAIL rstmid_active_before: got %b want 1", active); end
    rst_n = 1'b0;
    #1;
    total++; if (dv !== 1'b0)     begin bad++; $display("FAIL rstmid_dv: got %b want 0", dv); end
    total++; if (rbyte !== 8'h00) begin bad++; $display("FAIL rstmid_byte: got %h want 00", rbyte); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL rstmid_active: got %b want 0", active); end
    total++; if (ferr !== 1'b0)   begin bad++; $display("FAIL rstmid_ferr: got %b want 0", ferr); end
    last_good = 8'h00;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2 * CPB);
    total++; if (dv_cnt !== dv0 || err_cnt !== err0) begin bad++; $display("FAIL rstmid_no_pulse: got dv=%0d err=%0d want dv=%0d err=%0d", dv_cnt, err_cnt, dv0, err0); end
    send_frame(8'h5A, 1'b1, -1, 0);
    idle(3);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rstmid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL rstmid_byte_after: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  // Stretching or compressing every bit by one clock drifts a whole bit over a
  // frame at this rate, so a single randomly chosen bit carries the skew.
  task automatic test_skew();
    logic [7:0] e, g;
    send_frame(8'hC3, 1'b1, int'($urandom_range(0, 9)), CPB + 1);
    idle(2);
    send_frame(8'hC3, 1'b1, int'($urandom_range(0, 9)), CPB - 1);
    idle(3);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL skew_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL skew_byte: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] e, g;
    for (int i = 0; i < 10; i++) begin
      send_frame(8'($urandom), 1'b1, -1, 0);
      idle(int'($urandom_range(0, 3)));
    end
    idle(3);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL random_byte: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    total++; if (rbyte !== last_good) begin bad++; $display("FAIL random_byte_held: got %h want %h", rbyte, last_good); end
  endtask

  task automatic test_pulse_rules();
    total++; if (width_bad !== 0)  begin bad++; $display("FAIL pulse_width: got %0d want 0", width_bad); end
    total++; if (both_bad !== 0)   begin bad++; $display("FAIL pulse_overlap: got %0d want 0", both_bad); end
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL ferr_total: got %0d want %0d", err_cnt, exp_err); end
    total++; if (active_gap !== 0) begin bad++; $display("FAIL active_gap_total: got %0d want 0", active_gap); end
    total++; if (active_after_dv_bad !== 0) begin bad++; $display("FAIL active_after_dv_total: got %0d want 0", active_after_dv_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_skew();
    test_random();
    test_pulse_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx
